// File: rtl/apu_pkg.sv
// Shared APU types and NR10 field decoders.
// The register file drives NR10 inverted, so every field is complemented here.
package apu_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        WRITE = 2'd2,
        CHECK = 2'd3
    } sweep_state_t;

    localparam logic [10:0] FREQ_MAX = 11'h7FF;

    function automatic logic [2:0] nr10_period(input logic [6:0] nff10);
        return ~nff10[6:4];
    endfunction

    function automatic logic nr10_negate(input logic [6:0] nff10);
        return ~nff10[3];
    endfunction

    function automatic logic [2:0] nr10_shift(input logic [6:0] nff10);
        return ~nff10[2:0];
    endfunction

endpackage

// File: rtl/ch1_sweep_calc.sv
// Sweep arithmetic: shadow +/- (shadow >> shift), one bit wider than the frequency.
// Only an addition can carry into the top bit; a subtraction never goes below zero.
module ch1_sweep_calc #(
    parameter int FREQ_W = 11
) (
    input  logic [FREQ_W-1:0] shadow,
    input  logic [2:0]        shift,
    input  logic              negate,
    output logic [FREQ_W:0]   result,
    output logic              overflow
);
    logic [FREQ_W:0] ext;
    logic [FREQ_W:0] delta;

    assign ext      = {1'b0, shadow};
    assign delta    = ext >> shift;
    assign result   = negate ? (ext - delta) : (ext + delta);
    assign overflow = !negate && result[FREQ_W];

endmodule

// File: rtl/ch1_sweep.sv
// Channel-1 frequency sweep: shadow register, sweep timer and the
// IDLE/CALC/WRITE/CHECK sequencer that reloads the channel counter via acc_d/cope.
module ch1_sweep
    import apu_pkg::*;
#(
    parameter int FREQ_W         = 11,
    parameter int PERIOD_ZERO_AS = 8
) (
    input  logic              clk,
    input  logic              napu_reset,
    input  logic [6:0]        nff10,
    input  logic [FREQ_W-1:0] freq_in,
    input  logic              ch1_restart,
    input  logic              sweep_tick,
    output logic [FREQ_W-1:0] acc_d,
    output logic              cope,
    output logic              ch1_off,
    output logic              busy
);
    // Wide enough to hold the period-zero reload value without truncation.
    localparam int TMR_W = $clog2(PERIOD_ZERO_AS + 1);

    sweep_state_t      state, state_nx;
    logic [TMR_W-1:0]  timer, timer_reload;
    logic [FREQ_W-1:0] shadow, acc_q;
    logic              sw_en, neg_used;

    logic [2:0]        period, shift;
    logic              negate;
    logic [FREQ_W:0]   calc_res;
    logic              calc_ovf;
    logic              ovf_off, quirk, timer_expired;

    assign period = nr10_period(nff10);
    assign negate = nr10_negate(nff10);
    assign shift  = nr10_shift(nff10);

    assign timer_reload  = (period == 3'd0) ? TMR_W'(PERIOD_ZERO_AS) : TMR_W'(period);
    assign timer_expired = !(timer > TMR_W'(1));

    // Leaving negate mode after a subtraction has been used kills the channel.
    assign quirk = neg_used && !negate;

    ch1_sweep_calc #(.FREQ_W(FREQ_W)) u_calc (
        .shadow   (shadow),
        .shift    (shift),
        .negate   (negate),
        .result   (calc_res),
        .overflow (calc_ovf)
    );

    always_comb begin
        state_nx = state;
        cope     = 1'b0;
        ovf_off  = 1'b0;
        if (ch1_restart) begin
            // A trigger aborts any sequence in flight, including a pending WRITE.
            state_nx = (shift != 3'd0) ? CHECK : IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (sweep_tick && timer_expired && sw_en && period != 3'd0)
                        state_nx = CALC;
                end
                CALC: begin
                    if (calc_ovf) begin
                        ovf_off  = 1'b1;
                        state_nx = IDLE;
                    end else if (shift == 3'd0) begin
                        state_nx = IDLE;
                    end else begin
                        state_nx = WRITE;
                    end
                end
                WRITE: begin
                    cope     = 1'b1;
                    state_nx = CHECK;
                end
                CHECK: begin
                    ovf_off  = calc_ovf;
                    state_nx = IDLE;
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    assign ch1_off = ovf_off || quirk;
    assign acc_d   = cope ? calc_res[FREQ_W-1:0] : acc_q;
    assign busy    = (state != IDLE);

    always_ff @(posedge clk or negedge napu_reset) begin
        if (!napu_reset) begin
            state    <= IDLE;
            timer    <= '0;
            shadow   <= '0;
            acc_q    <= '0;
            sw_en    <= 1'b0;
            neg_used <= 1'b0;
        end else begin
            state <= state_nx;
            if (ch1_restart) begin
                shadow   <= freq_in;
                timer    <= timer_reload;
                sw_en    <= (period != 3'd0) || (shift != 3'd0);
                neg_used <= 1'b0;
            end else begin
                if (state == IDLE && sweep_tick)
                    timer <= timer_expired ? timer_reload : timer - TMR_W'(1);
                if ((state == CALC || state == CHECK) && negate)
                    neg_used <= 1'b1;
                if (cope) begin
                    shadow <= calc_res[FREQ_W-1:0];
                    acc_q  <= calc_res[FREQ_W-1:0];
                end
                if (ovf_off)
                    sw_en <= 1'b0;
                if (quirk) begin
                    sw_en    <= 1'b0;
                    neg_used <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_ch1_sweep.sv
// Self-checking bench for ch1_sweep: directed scenarios plus randomized
// trigger/tick runs checked against an arithmetic model of the sweep rules.
module tb_ch1_sweep;
    logic        clk = 1'b0;
    logic        napu_reset;
    logic [6:0]  nff10;
    logic [10:0] freq_in;
    logic        ch1_restart, sweep_tick;
    logic [10:0] acc_d;
    logic        cope, ch1_off, busy;
    int checks = 0;
    int errors = 0;

    ch1_sweep #(.FREQ_W(11), .PERIOD_ZERO_AS(8)) dut (
        .clk(clk), .napu_reset(napu_reset), .nff10(nff10), .freq_in(freq_in),
        .ch1_restart(ch1_restart), .sweep_tick(sweep_tick),
        .acc_d(acc_d), .cope(cope), .ch1_off(ch1_off), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] nf(input logic [7:0] nr10);
        return ~nr10[6:0];
    endfunction

    function automatic int sweep_calc(input int sh, input int s, input bit neg);
        return neg ? sh - (sh >> s) : sh + (sh >> s);
    endfunction

    // Drive inputs for one edge, then observe the cycle that follows it.
    task automatic cyc(input logic r, input logic t);
        ch1_restart = r; sweep_tick = t;
        @(posedge clk); #1;
        ch1_restart = 1'b0; sweep_tick = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        napu_reset = 1'b0; nff10 = 7'h7F; freq_in = '0; ch1_restart = 0; sweep_tick = 0;
        #12;
        checks++; if (acc_d !== 11'h0) begin errors++; $display("FAIL reset_acc got %h exp 0", acc_d); end
        checks++; if (cope !== 1'b0) begin errors++; $display("FAIL reset_cope got %b exp 0", cope); end
        checks++; if (ch1_off !== 1'b0) begin errors++; $display("FAIL reset_off got %b exp 0", ch1_off); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        napu_reset = 1'b1;
    endtask

    task automatic test_add_overflow();
        nff10 = nf(8'h11); freq_in = 11'h400;
        cyc(1, 0);
        checks++; if (ch1_off !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL t1_trig_check off=%b busy=%b exp 0 1", ch1_off, busy); end
        cyc(0, 0);
        cyc(0, 1);
        checks++; if (cope !== 1'b0 || ch1_off !== 1'b0) begin errors++; $display("FAIL t1_calc cope=%b off=%b exp 0 0", cope, ch1_off); end
        cyc(0, 0);
        checks++; if (cope !== 1'b1 || acc_d !== 11'h600) begin errors++; $display("FAIL t1_write cope=%b acc=%h exp 1 600", cope, acc_d); end
        cyc(0, 0);
        checks++; if (ch1_off !== 1'b1 || cope !== 1'b0) begin errors++; $display("FAIL t1_check_off off=%b cope=%b exp 1 0", ch1_off, cope); end
        cyc(0, 0);
        checks++; if (ch1_off !== 1'b0 || busy !== 1'b0 || acc_d !== 11'h600) begin errors++; $display("FAIL t1_idle off=%b busy=%b acc=%h exp 0 0 600", ch1_off, busy, acc_d); end
    endtask

    task automatic test_negate();
        logic [10:0] exp_acc;
        nff10 = nf(8'h19); freq_in = 11'h400;
        cyc(1, 0);
        checks++; if (ch1_off !== 1'b0) begin errors++; $display("FAIL t2_trig_off got %b exp 0", ch1_off); end
        cyc(0, 0);
        exp_acc = 11'h200;
        for (int k = 0; k < 2; k++) begin
            cyc(0, 1);
            checks++; if (ch1_off !== 1'b0) begin errors++; $display("FAIL t2_calc_off got %b exp 0", ch1_off); end
            cyc(0, 0);
            checks++; if (cope !== 1'b1 || acc_d !== exp_acc) begin errors++; $display("FAIL t2_write cope=%b acc=%h exp 1 %h", cope, acc_d, exp_acc); end
            cyc(0, 0);
            checks++; if (ch1_off !== 1'b0) begin errors++; $display("FAIL t2_check_off got %b exp 0", ch1_off); end
            cyc(0, 0);
            exp_acc = exp_acc >> 1;
        end
    endtask

    task automatic test_period0();
        nff10 = nf(8'h01); freq_in = 11'h7FF;
        cyc(1, 0);
        checks++; if (ch1_off !== 1'b1) begin errors++; $display("FAIL t3_trig_off got %b exp 1", ch1_off); end
        cyc(0, 0);
        checks++; if (ch1_off !== 1'b0) begin errors++; $display("FAIL t3_off_pulse got %b exp 0", ch1_off); end
        for (int k = 0; k < 3; k++) begin
            cyc(0, 1);
            for (int c = 0; c < 3; c++) begin
                checks++; if (cope !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL t3_no_cope cope=%b busy=%b exp 0 0", cope, busy); end
                cyc(0, 0);
            end
        end
    endtask

    task automatic test_shift0_shadow();
        nff10 = nf(8'h70); freq_in = 11'h123;
        cyc(1, 0);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL t4_trig_idle busy=%b exp 0", busy); end
        for (int pass = 0; pass < 2; pass++) begin
            for (int k = 1; k <= 7; k++) begin
                cyc(0, 1);
                checks++; if (busy !== (k == 7) || cope !== 1'b0) begin errors++; $display("FAIL t4_tick%0d busy=%b cope=%b exp %b 0", k, busy, cope, (k == 7)); end
                if (k < 7) cyc(0, 0);
            end
            cyc(0, 0);
            if (pass == 0) begin
                checks++; if (cope !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL t4_no_write cope=%b busy=%b exp 0 0", cope, busy); end
                freq_in = 11'h456; nff10 = nf(8'h71);
                cyc(0, 0);
            end else begin
                checks++; if (cope !== 1'b1 || acc_d !== 11'h1B4) begin errors++; $display("FAIL t4_shadow cope=%b acc=%h exp 1 1b4", cope, acc_d); end
                cyc(0, 0);
                checks++; if (ch1_off !== 1'b0) begin errors++; $display("FAIL t4_check_off got %b exp 0", ch1_off); end
                cyc(0, 0);
            end
        end
    endtask

    task automatic test_negate_quirk();
        nff10 = nf(8'h19); freq_in = 11'h400;
        cyc(1, 0); cyc(0, 0); cyc(0, 1); cyc(0, 0); cyc(0, 0); cyc(0, 0);
        checks++; if (ch1_off !== 1'b0) begin errors++; $display("FAIL t5_pre_off got %b exp 0", ch1_off); end
        nff10 = nf(8'h11);
        #1;
        checks++; if (ch1_off !== 1'b1) begin errors++; $display("FAIL t5_quirk_off got %b exp 1", ch1_off); end
        cyc(0, 0);
        checks++; if (ch1_off !== 1'b0) begin errors++; $display("FAIL t5_quirk_once got %b exp 0", ch1_off); end
        cyc(0, 1);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL t5_sweep_dead busy=%b exp 0", busy); end
        cyc(0, 0);
    endtask

    task automatic test_back_to_back();
        nff10 = nf(8'h11); freq_in = 11'h100;
        cyc(1, 0); cyc(0, 0);
        cyc(1, 1);
        checks++; if (busy !== 1'b1 || cope !== 1'b0) begin errors++; $display("FAIL t6_trig_wins busy=%b cope=%b exp 1 0", busy, cope); end
        cyc(0, 0);
        checks++; if (cope !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL t6_tick_dropped cope=%b busy=%b exp 0 0", cope, busy); end
        cyc(0, 1); cyc(0, 0);
        freq_in = 11'h080; ch1_restart = 1'b1;
        #1;
        checks++; if (cope !== 1'b0 || acc_d !== 11'h200) begin errors++; $display("FAIL t6_abort_write cope=%b acc=%h exp 0 200", cope, acc_d); end
        cyc(1, 0);
        checks++; if (busy !== 1'b1 || ch1_off !== 1'b0 || cope !== 1'b0) begin errors++; $display("FAIL t6_restart busy=%b off=%b cope=%b exp 1 0 0", busy, ch1_off, cope); end
        cyc(0, 0);
        checks++; if (cope !== 1'b0 || acc_d !== 11'h200) begin errors++; $display("FAIL t6_acc_hold cope=%b acc=%h exp 0 200", cope, acc_d); end
    endtask

    task automatic test_reset_mid();
        nff10 = nf(8'h11); freq_in = 11'h500;
        cyc(1, 0); cyc(0, 0); cyc(0, 1);
        napu_reset = 1'b0;
        #1;
        checks++; if (cope !== 0 || ch1_off !== 0 || busy !== 0 || acc_d !== 11'h0) begin errors++; $display("FAIL t7_reset_mid cope=%b off=%b busy=%b acc=%h exp 0 0 0 0", cope, ch1_off, busy, acc_d); end
        #3; napu_reset = 1'b1;
        for (int c = 0; c < 4; c++) begin
            cyc(0, 0);
            checks++; if (cope !== 1'b0 || ch1_off !== 1'b0) begin errors++; $display("FAIL t7_no_glitch cope=%b off=%b exp 0 0", cope, ch1_off); end
        end
    endtask

    task automatic test_random();
        int p, s, f, sh, tmr, n, m, ea;
        bit neg, sw, exp_off;
        bit eo[3];
        bit ec[3];
        logic [7:0] nr;
        for (int it = 0; it < 16; it++) begin
            p = $urandom_range(0, 7); s = $urandom_range(0, 7);
            neg = 1'($urandom_range(0, 1)); f = $urandom_range(0, 2047);
            nr = {1'b0, p[2:0], neg, s[2:0]};
            nff10 = ~nr[6:0]; freq_in = f[10:0];
            cyc(1, 0);
            sh = f; sw = (p != 0) || (s != 0); tmr = (p == 0) ? 8 : p; exp_off = 0;
            if (s != 0) begin
                m = sweep_calc(sh, s, neg);
                exp_off = (m > 2047);
                if (exp_off) sw = 0;
            end
            checks++; if (ch1_off !== exp_off || busy !== (s != 0)) begin errors++; $display("FAIL rnd%0d_trig off=%b busy=%b exp %b %b", it, ch1_off, busy, exp_off, (s != 0)); end
            cyc(0, 0);
            for (int k = 0; k < 2 * ((p == 0) ? 8 : p) + 1; k++) begin
                for (int c = 0; c < 3; c++) begin eo[c] = 0; ec[c] = 0; end
                ea = 0;
                if (tmr > 1) tmr--;
                else begin
                    tmr = (p == 0) ? 8 : p;
                    if (sw && p != 0) begin
                        n = sweep_calc(sh, s, neg);
                        if (n > 2047) begin eo[0] = 1; sw = 0; end
                        else if (s != 0) begin
                            ec[1] = 1; ea = n; sh = n;
                            m = sweep_calc(n, s, neg);
                            if (m > 2047) begin eo[2] = 1; sw = 0; end
                        end
                    end
                end
                cyc(0, 1);
                for (int c = 0; c < 3; c++) begin
                    checks++; if (cope !== ec[c] || ch1_off !== eo[c] || (ec[c] && acc_d !== 11'(ea))) begin errors++; $display("FAIL rnd%0d_tick%0d_c%0d cope=%b off=%b acc=%h exp %b %b %h", it, k, c, cope, ch1_off, acc_d, ec[c], eo[c], 11'(ea)); end
                    cyc(0, 0);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_add_overflow();
        test_negate();
        test_period0();
        test_shift0_shadow();
        test_negate_quirk();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
